mem_stage_lsu: RTL
==================

Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit of the 5-stage RV32I pipeline, between the E/M and M/W pipeline registers.
- Converts MemReadM/MemWriteM requests into a single-outstanding req/ready + rvalid data-bus transaction, with byte-enable generation and load sign/zero extension.
- Produces ReadDataM for the M/W register.
- Asserts StallM to freeze the pipeline while a bus access is outstanding.

Parameters:
- ADDR_W, 32, width of the bus address; ALUResultM[ADDR_W-1:0] is used.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- ALUResultM  in  32  effective address
- WriteDataM  in  32  store data (rs2)
- MemReadM  in  1  load in M stage
- MemWriteM  in  1  store in M stage
- Funct3M  in  3  access size/sign
- ReadDataM  out  32  extended load data to M/W register
- StallM  out  1  freeze IF..M stages and hold E/M register
- MisalignM  out  1  misaligned-access flag (see Optional Feature)
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ready  in  1  bus accepts request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  32  read data word

Behaviour:
- Reset (async, active-high): state=IDLE; rdata_q=0, off_q=0, f3_q=0.
  - All outputs are then 0: ReadDataM, StallM, MisalignM, mem_req, mem_we, mem_addr, mem_wdata, mem_be.
  - An outstanding transaction is abandoned. A later mem_rvalid is ignored because it arrives outside WAIT_R.
- The M stage advances on every clock edge where StallM=0.
- access = MemReadM | MemWriteM. If both are set, the access is a store.
- IDLE:
  - If access: mem_req=1, and mem_addr/mem_we/mem_be/mem_wdata are driven combinationally from the M inputs.
  - Store: if mem_ready=1, the store completes, StallM=0, stay IDLE. If mem_ready=0, StallM=1 and the request is held stable.
  - Load: if mem_ready=1, latch off_q=addr[1:0] and f3_q=Funct3M, then go to WAIT_R with StallM=1. If mem_ready=0, StallM=1 and stay IDLE.
  - No access: mem_req=0, StallM=0, ReadDataM=0.
- WAIT_R:
  - mem_req=0, StallM=1.
  - On mem_rvalid: rdata_q<=mem_rdata, go to DONE.
- DONE:
  - StallM=0, mem_req=0, ReadDataM=extend(rdata_q, off_q, f3_q).
  - Unconditional return to IDLE.
  - Load-to-use latency is therefore at least 3 cycles in M (accept, rvalid, DONE).
- Store encoding:
  - SB: be=4'b0001<<off, wdata={4{wd[7:0]}}.
  - SH: be=4'b0011<<{off[1],1'b0}, wdata={2{wd[15:0]}}.
  - SW (funct3 [1:0]=10 or 11): be=4'b1111, wdata=wd.
- Load extend:
  - 000 LB sign-extends byte[off].
  - 100 LBU zero-extends byte[off].
  - 001 LH sign-extends half[off[1]].
  - 101 LHU zero-extends half[off[1]].
  - 010 and undefined codes 011/110/111 return the full word.
- Reads always use mem_be=4'b1111.
- mem_rvalid in IDLE or DONE is ignored.
- mem_ready outside IDLE-with-access is ignored.
- At most one transaction is outstanding.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]!=0, is misaligned.
  - Misaligned access: mem_req=0, StallM=0, MisalignM=1 for that cycle, ReadDataM=0, no state change.
- Not defined: MisalignM tied 0; the offset bits beyond the access size are ignored (LH uses addr[1]; LW ignores addr[1:0]).

Decomposition:
- Package lsu_pkg: funct3 localparams (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU, F3_SB, F3_SH, F3_SW) and the state enum lsu_state_t {IDLE, WAIT_R, DONE}.
- Sub-module load_extend: combinational (word, off, funct3) -> 32-bit result; reused by the bench as a reference model.

Test Plan:
- SW addr 0x100, wd 0xDEADBEEF, mem_ready=1 same cycle -> mem_req=1, mem_be=1111, mem_addr=0x100, StallM=0 throughout.
- SB addr 0x103, wd 0x000000A5, mem_ready low 2 cycles -> StallM=1 for 2 cycles; then mem_be=1000, mem_wdata=0xA5A5A5A5, request stable while waiting.
- LB addr 0x102, rdata 0x12F45678, rvalid 3 cycles after accept -> StallM high until DONE; ReadDataM=0xFFFFFFF4 in DONE. Same access as LBU -> 0x000000F4.
- LH addr 0x102, rdata 0x8001ABCD -> 0xFFFF8001. LW same address with LSU_MISALIGN_TRAP_EN -> MisalignM=1, mem_req=0, StallM=0.
- Reset asserted in WAIT_R, then stray mem_rvalid after release -> state IDLE, all outputs 0, rvalid ignored, next LW completes normally.
- MemReadM and MemWriteM both set, Funct3M=010 -> treated as store: mem_we=1, no WAIT_R entry.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the memory-stage load/store unit:
//   - RV32I funct3 encodings for loads and stores
//   - lsu_state_t : bus-transaction sequencer states
// -----------------------------------------------------------------------------
package lsu_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store encodings (only funct3[1:0] is meaningful for stores)
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,  // no load outstanding; stores complete here
        WAIT_R = 2'd1,  // load accepted, waiting for read data
        DONE   = 2'd2   // read data captured, presented to M/W for one cycle
    } lsu_state_t;

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Combinational load-data alignment and sign/zero extension.
//   word   : in  32  raw bus read word
//   off    : in   2  byte offset of the access (addr[1:0])
//   funct3 : in   3  load size/sign encoding
//   result : out 32  value written back to the register file
// Byte loads select byte[off]; halfword loads select half[off[1]]; LW and the
// undefined encodings 011/110/111 return the full word.
// -----------------------------------------------------------------------------
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        byte_sel = word[{off, 3'b000} +: 8];
        half_sel = off[1] ? word[31:16] : word[15:0];
        result   = word;
        case (funct3)
            F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {24'h0, byte_sel};
            F3_LH:   result = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  result = {16'h0, half_sel};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// -----------------------------------------------------------------------------
// mem_stage_lsu
// Memory-stage load/store unit of the 5-stage RV32I pipeline. Turns
// MemReadM/MemWriteM into a single-outstanding req/ready + rvalid bus
// transaction and stalls the pipeline while a bus access is pending.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   ALUResultM          : in  32      effective address
//   WriteDataM          : in  32      store data (rs2)
//   MemReadM/MemWriteM  : in   1      load / store in M (both set = store)
//   Funct3M             : in   3      access size/sign
//   ReadDataM           : out 32      extended load data (valid in DONE)
//   StallM              : out  1      freeze IF..M and hold E/M
//   MisalignM           : out  1      misaligned-access flag
//   mem_req/we/addr     : out         bus request, write flag, word address
//   mem_wdata/mem_be    : out         lane-replicated data, byte enables
//   mem_ready           : in   1      bus accepts the request this cycle
//   mem_rvalid/rdata    : in          read data return
//
// Configuration
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned halfword/word accesses
//   raise MisalignM for one cycle and issue no bus request. When undefined,
//   MisalignM is tied 0 and offset bits beyond the access size are ignored.
// -----------------------------------------------------------------------------
module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ALUResultM,
    input  logic [31:0]       WriteDataM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        Funct3M,
    output logic [31:0]       ReadDataM,
    output logic              StallM,
    output logic              MisalignM,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    lsu_state_t  state, state_next;
    logic [31:0] rdata_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;

    logic        access;
    logic        misalign;
    logic        load_accept;
    logic [1:0]  off;
    logic [3:0]  store_be;
    logic [31:0] store_wdata;
    logic [31:0] ext_data;

    assign access = MemReadM | MemWriteM;
    assign off    = ALUResultM[1:0];

`ifdef LSU_MISALIGN_TRAP_EN
    // funct3[1:0]==01 is a halfword, funct3[1]==1 a word access.
    assign misalign = access &&
                      (((Funct3M[1:0] == 2'b01) && off[0]) ||
                       (Funct3M[1] && (off != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    // Store lane placement: data is replicated across lanes so the byte
    // enables alone select which bytes the memory updates.
    always_comb begin
        store_be    = 4'b1111;
        store_wdata = WriteDataM;
        case ({1'b0, Funct3M[1:0]})
            F3_SB: begin
                store_be    = 4'b0001 << off;
                store_wdata = {4{WriteDataM[7:0]}};
            end
            F3_SH: begin
                store_be    = 4'b0011 << {off[1], 1'b0};
                store_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                store_be    = 4'b1111;
                store_wdata = WriteDataM;
            end
        endcase
    end

    load_extend u_load_extend (
        .word   (rdata_q),
        .off    (off_q),
        .funct3 (f3_q),
        .result (ext_data)
    );

    // Next-state and outputs. Outputs are forced to 0 while reset is held so
    // the bus sees no request even if the M inputs carry a stale access.
    always_comb begin
        state_next  = state;
        load_accept = 1'b0;
        ReadDataM   = '0;
        StallM      = 1'b0;
        MisalignM   = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_be      = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (misalign) begin
                        MisalignM = 1'b1;
                    end else if (access) begin
                        mem_req   = 1'b1;
                        mem_we    = MemWriteM;
                        mem_addr  = {ALUResultM[ADDR_W-1:2], 2'b00};
                        mem_wdata = store_wdata;
                        mem_be    = MemWriteM ? store_be : 4'b1111;
                        if (MemWriteM) begin
                            StallM = !mem_ready;
                        end else begin
                            // Loads stall even on acceptance: data comes later.
                            StallM = 1'b1;
                            if (mem_ready) begin
                                load_accept = 1'b1;
                                state_next  = WAIT_R;
                            end
                        end
                    end
                end
                WAIT_R: begin
                    StallM = 1'b1;
                    if (mem_rvalid) state_next = DONE;
                end
                DONE: begin
                    ReadDataM  = ext_data;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            rdata_q <= '0;
            off_q   <= '0;
            f3_q    <= '0;
        end else begin
            state <= state_next;
            if (load_accept) begin
                off_q <= off;
                f3_q  <= Funct3M;
            end
            if ((state == WAIT_R) && mem_rvalid) begin
                rdata_q <= mem_rdata;
            end
        end
    end

endmodule
